tv_scan_ctrl: RTL and testbench

//  Sequencer for the GAP-TV horizontal-difference pass. On start it scans F frames,

---
 rtl/tv_scan_if.sv | 30 +++
 rtl/tv_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_tv_scan_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tv_scan_if.sv
// Bus between the GAP-TV iteration FSM / BRAM ports and the dx scan sequencer.
// start is a request taken only while idle; hold stalls read issue; ren/dp_vld/wen qualify their address, frame and tag fields.
interface tv_scan_if #(
  parameter int ADDR_W = 8,
  parameter int FNUM_W = 7
) ();
  logic              start;
  logic [FNUM_W-1:0] f_num;
  logic              hold;
  logic              busy;
  logic              done;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [FNUM_W-1:0] rfrm;
  logic              dp_vld;
  logic              dp_clr;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [FNUM_W-1:0] wfrm;

  modport master (
    input  start, f_num, hold,
    output busy, done, ren, raddr, rfrm, dp_vld, dp_clr, wen, waddr, wfrm
  );

  modport slave (
    output start, f_num, hold,
    input  busy, done, ren, raddr, rfrm, dp_vld, dp_clr, wen, waddr, wfrm
  );
endinterface

// File: rtl/tv_scan_ctrl.sv
// Right-to-left frame scan sequencer for the GAP-TV horizontal-difference pass.
// Issues BRAM reads, tags row starts for the dx datapath, and emits aligned write-back.
module tv_scan_ctrl #(
  parameter int COL_WIDTH = 2,
  parameter int ROW_NUM   = 48,
  parameter int ADDR_W    = 8,
  parameter int FNUM_W    = 7,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  tv_scan_if.master   bus,
  output logic [1:0]  dbg_state
);
  localparam int COL_W = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
  localparam int ROW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [FNUM_W-1:0] frm_q, frm_d;
  logic [FNUM_W-1:0] fnum_q, fnum_d;
  logic [1:0]        drn_q, drn_d;
  logic              ren_c;
  logic [ADDR_W-1:0] addr_c;

  // Stage i holds what was issued i+1 cycles ago; RD_LAT-1 feeds the datapath, RD_LAT the write port.
  logic [RD_LAT:0]   vld_q, vld_d;
  logic [RD_LAT:0]   clr_q, clr_d;
  logic [ADDR_W-1:0] adr_q [RD_LAT+1];
  logic [ADDR_W-1:0] adr_d [RD_LAT+1];
  logic [FNUM_W-1:0] fsel_q [RD_LAT+1];
  logic [FNUM_W-1:0] fsel_d [RD_LAT+1];

  assign addr_c = ADDR_W'(ADDR_W'(row_q) * ADDR_W'(COL_WIDTH) + ADDR_W'(col_q));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    frm_d   = frm_q;
    fnum_d  = fnum_q;
    drn_d   = drn_q;
    ren_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        row_d = '0;
        col_d = COL_LAST;
        frm_d = '0;
        drn_d = '0;
        if (bus.start) begin
          fnum_d  = bus.f_num;
          state_d = (bus.f_num == '0) ? S_FIN : S_SCAN;
        end
      end
      S_SCAN: begin
        if (!bus.hold) begin
          ren_c = 1'b1;
          if (col_q != '0) begin
            col_d = col_q - 1'b1;
          end else begin
            col_d = COL_LAST;
            if (row_q == ROW_LAST) begin
              row_d = '0;
              // Frame counter stops on the last frame rather than stepping past f_num-1.
              if (frm_q == fnum_q - FNUM_W'(1)) state_d = S_DRAIN;
              else                              frm_d   = frm_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (drn_q == 2'(RD_LAT)) begin
          drn_d   = '0;
          state_d = S_FIN;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_d     = {vld_q[RD_LAT-1:0], ren_c};
    clr_d     = {clr_q[RD_LAT-1:0], ren_c && (col_q == COL_LAST)};
    adr_d[0]  = ren_c ? addr_c : '0;
    fsel_d[0] = ren_c ? frm_q : '0;
    for (int i = 1; i <= RD_LAT; i++) begin
      adr_d[i]  = adr_q[i-1];
      fsel_d[i] = fsel_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= COL_LAST;
      frm_q   <= '0;
      fnum_q  <= '0;
      drn_q   <= '0;
      vld_q   <= '0;
      clr_q   <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        adr_q[i]  <= '0;
        fsel_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frm_q   <= frm_d;
      fnum_q  <= fnum_d;
      drn_q   <= drn_d;
      vld_q   <= vld_d;
      clr_q   <= clr_d;
      for (int i = 0; i <= RD_LAT; i++) begin
        adr_q[i]  <= adr_d[i];
        fsel_q[i] <= fsel_d[i];
      end
    end
  end

  assign bus.busy   = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign bus.done   = (state_q == S_FIN);
  assign bus.ren    = ren_c;
  assign bus.raddr  = adr_d[0];
  assign bus.rfrm   = fsel_d[0];
  assign bus.dp_vld = vld_q[RD_LAT-1];
  assign bus.dp_clr = clr_q[RD_LAT-1];
  assign bus.wen    = vld_q[RD_LAT];
  assign bus.waddr  = adr_q[RD_LAT];
  assign bus.wfrm   = fsel_q[RD_LAT];
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_tv_scan_ctrl.sv
// Scoreboard bench for tv_scan_ctrl: expected read/tag/write streams queued per run,
// a negedge monitor pops and compares them, run tasks check timing and counts.
module tb_tv_scan_ctrl;
  localparam int COL_WIDTH = 2;
  localparam int ROW_NUM   = 48;
  localparam int ADDR_W    = 8;
  localparam int FNUM_W    = 7;
  localparam int RD_LAT    = 1;
  localparam int WORDS     = ROW_NUM * COL_WIDTH;
  localparam int W         = FNUM_W + ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  tv_scan_if #(.ADDR_W(ADDR_W), .FNUM_W(FNUM_W)) bus ();

  tv_scan_ctrl #(
    .COL_WIDTH(COL_WIDTH), .ROW_NUM(ROW_NUM), .ADDR_W(ADDR_W),
    .FNUM_W(FNUM_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_r_q[$];
  logic [W-1:0] exp_w_q[$];
  logic         exp_c_q[$];

  int n_checks = 0, n_fail = 0;
  int ren_cnt, vld_cnt, wen_cnt, done_cnt, busy_cnt;
  int first_ren, last_ren, first_wen, last_wen, done_cyc;
  logic [W-1:0] e_mon;
  logic         c_mon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.ren) begin
      if (exp_r_q.size() == 0) check("ren_unexpected", 1, 0);
      else begin
        e_mon = exp_r_q.pop_front();
        check("ren_frm_addr", {bus.rfrm, bus.raddr}, e_mon);
      end
      if (ren_cnt == 0) first_ren = cyc;
      last_ren = cyc;
      ren_cnt++;
    end
    if (bus.dp_vld) begin
      if (exp_c_q.size() == 0) check("dp_vld_unexpected", 1, 0);
      else begin
        c_mon = exp_c_q.pop_front();
        check("dp_clr", bus.dp_clr, c_mon);
      end
      vld_cnt++;
    end else if (bus.dp_clr) begin
      check("dp_clr_without_vld", 1, 0);
    end
    if (bus.wen) begin
      if (exp_w_q.size() == 0) check("wen_unexpected", 1, 0);
      else begin
        e_mon = exp_w_q.pop_front();
        check("wen_frm_addr", {bus.wfrm, bus.waddr}, e_mon);
      end
      if (wen_cnt == 0) first_wen = cyc;
      last_wen = cyc;
      wen_cnt++;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_low_at_done", bus.busy, 0);
    end
    if (bus.busy) busy_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    ren_cnt = 0; vld_cnt = 0; wen_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_ren = -1; last_ren = -1; first_wen = -1; last_wen = -1; done_cyc = -1;
    exp_r_q.delete(); exp_w_q.delete(); exp_c_q.delete();
  endtask

  // Right-to-left within each row: addresses 1,0,3,2,...,95,94 per frame.
  task automatic fill(input int fnum);
    logic [W-1:0] v;
    for (int f = 0; f < fnum; f++)
      for (int r = 0; r < ROW_NUM; r++)
        for (int c = COL_WIDTH - 1; c >= 0; c--) begin
          v = {FNUM_W'(f), ADDR_W'(r * COL_WIDTH + c)};
          exp_r_q.push_back(v);
          exp_w_q.push_back(v);
          exp_c_q.push_back(c == COL_WIDTH - 1);
        end
  endtask

  task automatic pulse_start(input int fnum, output int acc);
    @(posedge clk); #1;
    bus.f_num = FNUM_W'(fnum);
    bus.start = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_ren"}, bus.ren, 0);
    check({tag, "_raddr"}, bus.raddr, 0);
    check({tag, "_rfrm"}, bus.rfrm, 0);
    check({tag, "_dp_vld"}, bus.dp_vld, 0);
    check({tag, "_dp_clr"}, bus.dp_clr, 0);
    check({tag, "_wen"}, bus.wen, 0);
    check({tag, "_waddr"}, bus.waddr, 0);
    check({tag, "_wfrm"}, bus.wfrm, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic run_scan(input int fnum, input int hold_len, input bit restart);
    int acc, tmo, hold_left;
    bit hold_seen, rs_seen;
    clear_stats();
    fill(fnum);
    pulse_start(fnum, acc);
    tmo = 0; hold_left = 0; hold_seen = 0; rs_seen = 0;
    while (done_cnt == 0 && tmo < 2000) begin
      @(posedge clk); #1;
      if (hold_len > 0 && !hold_seen && ren_cnt == 1) begin
        bus.hold = 1'b1;
        hold_left = hold_len;
        hold_seen = 1;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) bus.hold = 1'b0;
      end
      if (restart && !rs_seen && ren_cnt == 20) begin
        bus.start = 1'b1;
        bus.f_num = FNUM_W'(5);
        rs_seen = 1;
      end else begin
        bus.start = 1'b0;
      end
      tmo++;
    end
    if (tmo >= 2000) check("done_timeout", 0, 1);
    repeat (5) @(posedge clk);
    #1;
    check("done_count", done_cnt, 1);
    check("exp_r_q_empty", exp_r_q.size(), 0);
    check("exp_w_q_empty", exp_w_q.size(), 0);
    check("exp_c_q_empty", exp_c_q.size(), 0);
    if (fnum == 0) begin
      check("done_latency_f0", done_cyc, acc);
      check("ren_cnt_f0", ren_cnt, 0);
      check("wen_cnt_f0", wen_cnt, 0);
      check("busy_cnt_f0", busy_cnt, 0);
    end else begin
      check("first_ren_cycle", first_ren, acc);
      check("ren_cnt", ren_cnt, WORDS * fnum);
      check("ren_span", last_ren - first_ren, WORDS * fnum - 1 + hold_len);
      check("first_wen_cycle", first_wen, first_ren + RD_LAT + 1);
      check("last_wen_cycle", last_wen, last_ren + RD_LAT + 1);
      check("wen_cnt", wen_cnt, WORDS * fnum);
      check("done_after_last_wen", done_cyc, last_wen + 1);
      check("busy_cycles", busy_cnt, done_cyc - acc);
    end
  endtask

  // Reset lands on the edge ending the 40th read cycle; reads 39/40 never reach write-back.
  task automatic run_abort();
    int acc, tmo;
    clear_stats();
    fill(1);
    pulse_start(1, acc);
    tmo = 0;
    while (ren_cnt < 39 && tmo < 500) begin
      @(posedge clk); #1;
      tmo++;
    end
    if (tmo >= 500) check("abort_timeout", 0, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_r_q.delete(); exp_w_q.delete(); exp_c_q.delete();
    check("abort_ren_cnt", ren_cnt, 40);
    check("abort_wen_cnt", wen_cnt, 38);
    @(negedge clk);
    check_idle("after_abort");
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_more_wen", wen_cnt, 38);
    check("abort_no_more_ren", ren_cnt, 40);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.f_num = '0;
    bus.hold  = 1'b0;
    clear_stats();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_scan(1, 0, 0);
    run_scan(3, 0, 0);
    run_scan(0, 0, 0);
    run_scan(1, 5, 0);
    run_scan(1, 0, 1);
    run_abort();
    run_scan(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
